abus_share_arbiter: RTL and testbench
=====================================

Name: abus_share_arbiter

Overview:
Time-shares one analog bus segment between NUM_REQ requesters by sequencing the switch enables of the bus-connect switches.
- Guarantees break-before-make: all switches are open for a dead time before any switch closes.
- Grants ownership only after a settling interval.
- Selects the next owner round-robin.
- Sits between digital requesters (ADC/comparator sequencers) and the analog connect/mux switch controls.

Parameters:
NUM_REQ, 4, number of requesters; 2..8
OWNER_W, 2, width of owner index; ceil(log2(NUM_REQ)), minimum 1
DEAD_CYCLES, 2, cycles with all switches open after any release; 1..255
SETTLE_CYCLES, 8, cycles between switch closure and grant; 1..255
HOLD_MAX, 255, maximum grant hold before forced release; 1..255; used only with ABUS_ARB_TIMEOUT_EN

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  level request per requester; held high while the bus is needed
sw_en  output  NUM_REQ  one-hot-or-zero switch enable to the bus-connect switches; registered
grant  output  NUM_REQ  one-hot-or-zero; bus settled and owned; registered
owner  output  OWNER_W  index of the current or last owner; registered
busy  output  1  high in any state other than IDLE; registered
timeout  output  1  one-cycle pulse on forced release; constant 0 without ABUS_ARB_TIMEOUT_EN

Behaviour:
- Reset, sampled on a clock edge:
  - state = IDLE; sw_en = 0, grant = 0, owner = 0, busy = 0, timeout = 0.
  - rr_ptr = 0, all counters = 0.
  - Reset asserted mid-operation opens every switch on that edge; no dead time is applied. Reset dominates all other inputs.
- States: IDLE, SETTLE, OWNED, DEAD.
- IDLE:
  - If req is non-zero, the winner is the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: state = SETTLE, sw_en[winner] = 1, owner = winner, settle counter = SETTLE_CYCLES - 1.
  - If req is zero, stay in IDLE.
- SETTLE:
  - Counter decrements each cycle.
  - When counter = 0 and req[owner] = 1: next edge state = OWNED, grant[owner] = 1.
  - Latency: req sampled at edge N gives sw_en high after edge N and grant high after edge N + SETTLE_CYCLES.
  - If req[owner] drops during SETTLE: next edge sw_en = 0, state = DEAD; grant never asserts.
- OWNED:
  - sw_en and grant are held while req[owner] = 1. Other requests are ignored.
  - On req[owner] = 0: next edge sw_en = 0, grant = 0, state = DEAD.
  - Dead counter = DEAD_CYCLES - 1; rr_ptr = (owner + 1) mod NUM_REQ.
- DEAD:
  - sw_en = 0, grant = 0.
  - Counter decrements; at 0, next edge state = IDLE.
  - Minimum gap from sw_en falling to any sw_en rising is DEAD_CYCLES + 1 cycles.
- Invariants:
  - popcount(sw_en) ≤ 1 at all times.
  - grant implies sw_en for the same bit.
  - grant is never high in SETTLE or DEAD.
- Simultaneous events:
  - Owner drops while another requester raises req: the normal DEAD sequence runs, then arbitration in IDLE.
  - The former owner re-requests immediately: it loses to any other pending requester (rr_ptr has moved past it).
  - A lone requester may regain the bus after DEAD.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- Request bits at index ≥ NUM_REQ do not exist; no X propagation from an unused owner encoding.

Optional Feature:
- Macro: ABUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OWNED and increments each OWNED cycle, saturating.
  - When the count reaches HOLD_MAX and any other req bit is high: next edge grant = 0, sw_en = 0, timeout = 1 for one cycle, state = DEAD, rr_ptr = owner + 1.
  - If no other request is pending, the owner keeps the bus indefinitely.
- Undefined: no hold counter; timeout is tied to 0; the owner holds the bus until it deasserts req.

Test Plan:
All scenarios use NUM_REQ=4, DEAD_CYCLES=2, SETTLE_CYCLES=3.
1. Reset then req=0001 at edge 10 -> sw_en=0001 after edge 10; grant=0001 after edge 13; owner=0, busy=1.
2. While requester 0 is OWNED, drop req[0] at edge 20 with req=0110 -> sw_en=0000 after edge 20; DEAD through edge 22; sw_en=0010 after edge 23; grant=0010 after edge 26.
3. req=1111 held, each owner releases 2 cycles after grant -> grant order 0,1,2,3,0; popcount(sw_en) ≤ 1 every cycle.
4. req[2] drops one cycle into SETTLE -> grant never asserts; sw_en cleared next edge; DEAD for 2 cycles, then IDLE.
5. Assert reset while OWNED -> sw_en=0, grant=0, busy=0, owner=0 after that edge; first grant after reset is again requester 0 when req=1111.
6. With ABUS_ARB_TIMEOUT_EN and HOLD_MAX=5: req=0011 held, requester 0 owns -> after 5 OWNED cycles timeout pulses 1 cycle; grant passes to requester 1 after DEAD+SETTLE. Without the macro -> timeout stays 0 and requester 0 holds indefinitely.

Source files
------------

// File: rtl/abus_share_arbiter.sv
// Break-before-make, round-robin time-sharing of one analog bus segment between NUM_REQ requesters.
// Optional hold-timeout forced release is enabled by defining ABUS_ARB_TIMEOUT_EN.
module abus_share_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned OWNER_W       = 2,
    parameter int unsigned DEAD_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned HOLD_MAX      = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] sw_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic               timeout
);

    localparam int unsigned CNT_W = 8;

    // Elaboration-time range check of the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || OWNER_W < 1 || (1 << OWNER_W) < NUM_REQ ||
        DEAD_CYCLES < 1 || DEAD_CYCLES > 255 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_param_check
        $error("abus_share_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWNED  = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [NUM_REQ-1:0] sw_en_d, grant_d;
    logic [OWNER_W-1:0] owner_d, rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d;

    logic [NUM_REQ-1:0] own_mask;
    logic               req_own;
    logic [OWNER_W-1:0] owner_inc;
    logic               any_req;
    logic [OWNER_W-1:0] winner;

`ifdef ABUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold, hold_d;
    logic             timeout_d;
    logic             others_pending;
`endif

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [OWNER_W-1:0] idx);
        logic [NUM_REQ-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == OWNER_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Owner decode; a mask compare avoids indexing req with an unused owner encoding.
    assign own_mask  = to_onehot(owner);
    assign req_own   = |(req & own_mask);
    assign owner_inc = (owner == OWNER_W'(NUM_REQ - 1)) ? '0 : owner + OWNER_W'(1);

`ifdef ABUS_ARB_TIMEOUT_EN
    assign others_pending = |(req & ~own_mask);
`endif

    // Round-robin pick: first request at or above rr_ptr, else the lowest request (wrap).
    always_comb begin
        logic               found_hi, found_lo;
        logic [OWNER_W-1:0] win_hi, win_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = OWNER_W'(i);
            end
            if (req[i] && !found_hi && (OWNER_W'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                win_hi   = OWNER_W'(i);
            end
        end
        any_req = found_lo;
        winner  = found_hi ? win_hi : win_lo;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        sw_en_d  = sw_en;
        grant_d  = grant;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        cnt_d    = cnt;
`ifdef ABUS_ARB_TIMEOUT_EN
        hold_d    = hold;
        timeout_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                sw_en_d = '0;
                grant_d = '0;
                if (any_req) begin
                    state_d = SETTLE;
                    sw_en_d = to_onehot(winner);
                    owner_d = winner;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (!req_own) begin
                    // Aborted before grant: open the switch and still honour the dead time.
                    state_d = DEAD;
                    sw_en_d = '0;
                    grant_d = '0;
                    cnt_d   = CNT_W'(DEAD_CYCLES - 1);
                end else if (cnt == '0) begin
                    state_d = OWNED;
                    grant_d = own_mask;
`ifdef ABUS_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            OWNED: begin
                if (!req_own) begin
                    state_d  = DEAD;
                    sw_en_d  = '0;
                    grant_d  = '0;
                    cnt_d    = CNT_W'(DEAD_CYCLES - 1);
                    rr_ptr_d = owner_inc;
`ifdef ABUS_ARB_TIMEOUT_EN
                end else if ((hold >= CNT_W'(HOLD_MAX)) && others_pending) begin
                    state_d   = DEAD;
                    sw_en_d   = '0;
                    grant_d   = '0;
                    cnt_d     = CNT_W'(DEAD_CYCLES - 1);
                    rr_ptr_d  = owner_inc;
                    timeout_d = 1'b1;
                end else if (hold != '1) begin
                    hold_d = hold + CNT_W'(1);
`endif
                end
            end
            DEAD: begin
                sw_en_d = '0;
                grant_d = '0;
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sw_en_d = '0;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset opens every switch immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sw_en  <= '0;
            grant  <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
            cnt    <= '0;
`ifdef ABUS_ARB_TIMEOUT_EN
            hold    <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            sw_en  <= sw_en_d;
            grant  <= grant_d;
            owner  <= owner_d;
            busy   <= busy_d;
            rr_ptr <= rr_ptr_d;
            cnt    <= cnt_d;
`ifdef ABUS_ARB_TIMEOUT_EN
            hold    <= hold_d;
            timeout <= timeout_d;
`endif
        end
    end

`ifndef ABUS_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_abus_share_arbiter.sv
// Directed self-checking bench for abus_share_arbiter (NUM_REQ=4, DEAD=2, SETTLE=3, HOLD_MAX=5).
module tb_abus_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned OWNER_W = 2;

    logic               clock;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] sw_en;
    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               timeout;

    int checks = 0;
    int errors = 0;

    abus_share_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .OWNER_W      (OWNER_W),
        .DEAD_CYCLES  (2),
        .SETTLE_CYCLES(3),
        .HOLD_MAX     (5)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .sw_en  (sw_en),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Structural invariants sampled every cycle on the falling edge.
    always @(negedge clock) begin
        checks++;
        if ($countones(sw_en) > 1 || (grant & ~sw_en) != '0) begin
            errors++;
            $display("FAIL invariant: sw_en=%b grant=%b (need popcount<=1, grant within sw_en)", sw_en, grant);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sw_en !== 4'b0000 || grant !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sw_en=%b grant=%b owner=%0d busy=%b timeout=%b, need all zero",
                     sw_en, grant, owner, busy, timeout);
        end
    endtask

    task automatic test_first_grant();
        req = 4'b0001;
        tick();
        checks++;
        if (sw_en !== 4'b0001 || grant !== 4'b0000 || owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_settle: sw_en=%b grant=%b owner=%0d busy=%b, need 0001 0000 0 1",
                     sw_en, grant, owner, busy);
        end
        tick(2);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL first_early_grant: grant=%b, need 0000", grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || sw_en !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: grant=%b sw_en=%b owner=%0d busy=%b, need 0001 0001 0 1",
                     grant, sw_en, owner, busy);
        end
    endtask

    task automatic test_handover();
        tick(2);
        req = 4'b0110;
        tick();
        checks++;
        if (sw_en !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL handover_release: sw_en=%b grant=%b busy=%b, need 0000 0000 1", sw_en, grant, busy);
        end
        tick();
        checks++;
        if (sw_en !== 4'b0000) begin
            errors++;
            $display("FAIL handover_dead1: sw_en=%b, need 0000", sw_en);
        end
        tick();
        checks++;
        if (sw_en !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handover_dead2: sw_en=%b busy=%b, need 0000 0", sw_en, busy);
        end
        tick();
        checks++;
        if (sw_en !== 4'b0010 || owner !== 2'd1 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL handover_settle: sw_en=%b owner=%0d grant=%b, need 0010 1 0000", sw_en, owner, grant);
        end
        tick(2);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL handover_early_grant: grant=%b, need 0000", grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL handover_grant: grant=%b, need 0010", grant);
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int  budget;
            budget = 0;
            while (grant == '0 && budget < 20) begin
                tick();
                budget++;
            end
            checks++;
            if (grant !== exp_order[k]) begin
                errors++;
                $display("FAIL rr_order_%0d: grant=%b, need %b", k, grant, exp_order[k]);
            end
            if (grant == '0) begin
                tick();
                continue;
            end
            tick(2);
            req = req & ~exp_order[k];
            tick();
            checks++;
            if (sw_en !== 4'b0000 || grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_release_%0d: sw_en=%b grant=%b, need 0000 0000", k, sw_en, grant);
            end
            req = 4'b1111;
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_settle_abort();
        bit saw_grant;
        saw_grant = 1'b0;
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (sw_en !== 4'b0100 || owner !== 2'd2) begin
            errors++;
            $display("FAIL abort_settle: sw_en=%b owner=%0d, need 0100 2", sw_en, owner);
        end
        req = 4'b0000;
        tick();
        if (grant != '0) saw_grant = 1'b1;
        checks++;
        if (sw_en !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_open: sw_en=%b busy=%b, need 0000 1", sw_en, busy);
        end
        tick();
        if (grant != '0) saw_grant = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_dead: busy=%b, need 1", busy);
        end
        tick();
        if (grant != '0) saw_grant = 1'b1;
        checks++;
        if (busy !== 1'b0 || saw_grant) begin
            errors++;
            $display("FAIL abort_idle: busy=%b saw_grant=%b, need 0 0", busy, saw_grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick(4);
        req = 4'b0000;
        tick(4);
        req = 4'b0100;
        tick(4);
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid_owned: grant=%b owner=%0d, need 0100 2", grant, owner);
        end
        req   = 4'b1111;
        reset = 1'b1;
        tick();
        checks++;
        if (sw_en !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: sw_en=%b grant=%b busy=%b owner=%0d, need 0000 0000 0 0",
                     sw_en, grant, busy, owner);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (sw_en !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_winner: sw_en=%b owner=%0d, need 0001 0", sw_en, owner);
        end
        tick(3);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_grant: grant=%b, need 0001", grant);
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick(4);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL to_owned: grant=%b, need 0001", grant);
        end
`ifdef ABUS_ARB_TIMEOUT_EN
        begin
            int budget;
            budget = 0;
            while (timeout !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            checks++;
            if (timeout !== 1'b1 || grant !== 4'b0000 || sw_en !== 4'b0000) begin
                errors++;
                $display("FAIL to_pulse: timeout=%b grant=%b sw_en=%b, need 1 0000 0000", timeout, grant, sw_en);
            end
            tick();
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_one_cycle: timeout=%b, need 0", timeout);
            end
            tick(5);
            checks++;
            if (grant !== 4'b0010) begin
                errors++;
                $display("FAIL to_handover: grant=%b, need 0010", grant);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || grant !== 4'b0001) begin
                errors++;
                $display("FAIL to_hold_%0d: timeout=%b grant=%b, need 0 0001", i, timeout, grant);
            end
        end
`endif
        req = 4'b0000;
        tick(4);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        test_reset();
        test_first_grant();
        test_handover();
        test_round_robin();
        test_settle_abort();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
